mem_pipe_err: RTL and testbench

MEM_PIPE_ERR -- requirements
Module: mem_pipe_err

---
 rtl/mem_pipe_err_if.sv | 34 +++
 rtl/mem_pipe_err.sv | 127 ++++++++++++
 tb/tb_mem_pipe_err.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pipe_err_if.sv
// Bus bundle for mem_pipe_err: request strobes in, read data, error
// events and error statistics out.
interface mem_pipe_err_if #(
  parameter int DATA_WD = 32,
  parameter int DEPTH   = 512,
  parameter int ADDR_WD = $clog2(DEPTH),
  parameter int CNT_WD  = 8
);
  logic               i_wr_en;
  logic               i_rd_en;
  logic [ADDR_WD-1:0] i_addr;
  logic [DATA_WD-1:0] i_data;
  logic               i_err_clr;
  logic               o_rvalid;
  logic [DATA_WD-1:0] o_rdata;
  logic               o_1bit_event;
  logic               o_2bit_event;
  logic [ADDR_WD-1:0] o_err_addr;
  logic               o_err_sticky;
  logic [CNT_WD-1:0]  o_1bit_cnt;
  logic [CNT_WD-1:0]  o_2bit_cnt;

  modport master (
    output i_wr_en, i_rd_en, i_addr, i_data, i_err_clr,
    input  o_rvalid, o_rdata, o_1bit_event, o_2bit_event,
           o_err_addr, o_err_sticky, o_1bit_cnt, o_2bit_cnt
  );

  modport slave (
    input  i_wr_en, i_rd_en, i_addr, i_data, i_err_clr,
    output o_rvalid, o_rdata, o_1bit_event, o_2bit_event,
           o_err_addr, o_err_sticky, o_1bit_cnt, o_2bit_cnt
  );
endinterface

// File: rtl/mem_pipe_err.sv
// Single-port memory with a fixed-latency read pipeline and a simple
// address/data parity-style error checker with sticky capture and
// saturating counters.
module mem_pipe_err #(
  parameter int DATA_WD  = 32,
  parameter int DEPTH    = 512,
  parameter int DELAY    = 3,
  parameter int ADDR_WD  = $clog2(DEPTH),
  parameter int ERR_MODE = 3,
  parameter int CNT_WD   = 8
) (
  input logic           clk,
  input logic           rst_n,
  mem_pipe_err_if.slave bus
);

  localparam bit CHK1 = (ERR_MODE == 1) || (ERR_MODE == 3);
  localparam bit CHK2 = (ERR_MODE == 2) || (ERR_MODE == 3);
  localparam int A1   = (ADDR_WD > 1) ? 1 : 0;

  typedef struct packed {
    logic               vld;
    logic               oob;
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] data;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{vld: 1'b0, oob: 1'b0, addr: '0, data: '1};

  logic [DATA_WD-1:0] mem [DEPTH];

  // Stage 0 samples the request and the pre-write memory word; stage
  // DELAY is what the outputs show.
  stage_t             stg_q [DELAY+1];
  stage_t             stg_d [DELAY+1];
  stage_t             out_s;

  logic [CNT_WD-1:0]  cnt1_q, cnt1_d;
  logic [CNT_WD-1:0]  cnt2_q, cnt2_d;
  logic               sticky_q, sticky_d;
  logic [ADDR_WD-1:0] err_addr_q, err_addr_d;

  logic               in_range;
  logic               addr_b1;
  logic               raw1, raw2, ev1, ev2;

  assign in_range = ({1'b0, bus.i_addr} < (ADDR_WD+1)'(DEPTH));

  // Memory array write; the read side samples the same edge and so sees old data.
  // NOTE: memory has no reset -- clearing it would need DEPTH write cycles and contents must survive rst_n.
  always_ff @(posedge clk) begin
    if (bus.i_wr_en && in_range) mem[bus.i_addr] <= bus.i_data;
  end

  // Next state of the read pipeline: load stage 0, shift the rest.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stg_d[0] = STAGE_IDLE;
    if (bus.i_rd_en) begin
      stg_d[0].vld  = 1'b1;
      stg_d[0].oob  = !in_range;
      stg_d[0].addr = bus.i_addr;
      stg_d[0].data = in_range ? mem[bus.i_addr] : '1;
    end
    for (int i = 1; i <= DELAY; i++) stg_d[i] = stg_q[i-1];
  end

  assign out_s   = stg_q[DELAY];
  assign addr_b1 = (ADDR_WD > 1) ? out_s.addr[A1] : 1'b0;

  // Error classification of the read on the outputs; a 2-bit hit masks the 1-bit one.
  always_comb begin
    raw1 = CHK1 && out_s.vld && !out_s.oob && (out_s.addr[0] ^ out_s.data[0]);
    raw2 = CHK2 && out_s.vld && !out_s.oob && (addr_b1 ^ out_s.data[1]);
    ev2  = raw2;
    ev1  = raw1 && !raw2;
  end

  // Error statistics next state; a clear discards any event in the same cycle.
  always_comb begin
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    sticky_d   = sticky_q;
    err_addr_d = err_addr_q;
    if (bus.i_err_clr) begin
      cnt1_d     = '0;
      cnt2_d     = '0;
      sticky_d   = 1'b0;
      err_addr_d = '0;
    end else begin
      if (ev1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
      if (ev2 && (cnt2_q != '1)) cnt2_d = cnt2_q + 1'b1;
      if ((ev1 || ev2) && !sticky_q) begin
        sticky_d   = 1'b1;
        err_addr_d = out_s.addr;
      end
    end
  end

  // State registers; reset flushes the pipeline and clears statistics.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DELAY; i++) stg_q[i] <= STAGE_IDLE;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      for (int i = 0; i <= DELAY; i++) stg_q[i] <= stg_d[i];
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.o_rvalid     = out_s.vld;
  assign bus.o_rdata      = out_s.data;
  assign bus.o_1bit_event = ev1;
  assign bus.o_2bit_event = ev2;
  assign bus.o_err_addr   = err_addr_q;
  assign bus.o_err_sticky = sticky_q;
  assign bus.o_1bit_cnt   = cnt1_q;
  assign bus.o_2bit_cnt   = cnt2_q;

endmodule

// File: tb/tb_mem_pipe_err.sv
// Directed bench for mem_pipe_err: a scoreboard of expected read results
// is filled as reads are issued and drained as o_rvalid appears. A second
// instance with CNT_WD=2 shares the stimulus to show counter saturation.
module tb_mem_pipe_err;

  localparam int DW = 32;
  localparam int DP = 512;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_pipe_err_if #(.DATA_WD(DW), .DEPTH(DP), .ADDR_WD(AW), .CNT_WD(8)) bus ();
  mem_pipe_err_if #(.DATA_WD(DW), .DEPTH(DP), .ADDR_WD(AW), .CNT_WD(2)) bus2 ();

  assign bus2.i_wr_en   = bus.i_wr_en;
  assign bus2.i_rd_en   = bus.i_rd_en;
  assign bus2.i_addr    = bus.i_addr;
  assign bus2.i_data    = bus.i_data;
  assign bus2.i_err_clr = bus.i_err_clr;

  mem_pipe_err #(.DATA_WD(DW), .DEPTH(DP), .DELAY(3), .ADDR_WD(AW),
                 .ERR_MODE(3), .CNT_WD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  mem_pipe_err #(.DATA_WD(DW), .DEPTH(DP), .DELAY(3), .ADDR_WD(AW),
                 .ERR_MODE(3), .CNT_WD(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [DW-1:0] data;
    logic          e1;
    logic          e2;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DP];
  int            total = 0;
  int            bad   = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; read expectations use the model before the write lands.
  task automatic step(input logic wr, input logic rd, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    exp_t e;
    bus.i_wr_en = wr;
    bus.i_rd_en = rd;
    bus.i_addr  = addr;
    bus.i_data  = data;
    if (rd) begin
      e.data = model[addr];
      e.e2   = addr[1] ^ e.data[1];
      e.e1   = (addr[0] ^ e.data[0]) & ~e.e2;
      sb.push_back(e);
    end
    if (wr) model[addr] = data;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_stats(input string tag, input int c1, input int c2,
                             input int stk, input int ea);
    check({tag, "_cnt1"},   32'(bus.o_1bit_cnt),   c1);
    check({tag, "_cnt2"},   32'(bus.o_2bit_cnt),   c2);
    check({tag, "_sticky"}, 32'(bus.o_err_sticky), stk);
    check({tag, "_eaddr"},  32'(bus.o_err_addr),   ea);
  endtask

  // Output monitor: pops the scoreboard on every valid read, checks idle values otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_rvalid) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'(bus.o_rvalid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", bus.o_rdata, e.data);
          check("ev1", 32'(bus.o_1bit_event), 32'(e.e1));
          check("ev2", 32'(bus.o_2bit_event), 32'(e.e2));
        end
      end else begin
        check("idle_rdata", bus.o_rdata, 32'hFFFF_FFFF);
        check("idle_ev", {30'd0, bus.o_1bit_event, bus.o_2bit_event}, 0);
      end
    end
  end

  initial begin
    int lat;
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_addr = '0;
    bus.i_data = '0;    bus.i_err_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(bus.o_rvalid), 0);
    check("rst_rdata", bus.o_rdata, 32'hFFFF_FFFF);
    check("rst_ev", {30'd0, bus.o_1bit_event, bus.o_2bit_event}, 0);
    check_stats("rst", 0, 0, 0, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic write then read with latency measurement
    step(1'b1, 1'b0, 9'd2, 32'hA5A5_A5A6);
    step(1'b0, 1'b1, 9'd2, '0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.o_rvalid) break;
    end
    check("latency", lat, 3);
    wait_drain();
    check_stats("clean", 0, 0, 0, 0);

    // Top address and same-cycle write/read of one word
    step(1'b1, 1'b0, 9'd511, 32'h1234_5677);
    step(1'b0, 1'b1, 9'd511, '0);
    step(1'b1, 1'b0, 9'd5, 32'h0000_0001);
    step(1'b1, 1'b1, 9'd5, 32'hFFFF_FFF1);
    step(1'b0, 1'b1, 9'd5, '0);
    wait_drain();
    check_stats("rbw", 0, 0, 0, 0);

    // 1-bit error, then a 2-bit-only error that must not move the captured address
    step(1'b1, 1'b0, 9'd1, 32'h0);
    step(1'b0, 1'b1, 9'd1, '0);
    wait_drain();
    check_stats("err1", 1, 0, 1, 1);
    step(1'b1, 1'b0, 9'd3, 32'h0);
    step(1'b0, 1'b1, 9'd3, '0);
    wait_drain();
    check_stats("err2", 1, 1, 1, 1);

    // Three back-to-back reads give three consecutive valid cycles
    step(1'b0, 1'b1, 9'd2, '0);
    step(1'b0, 1'b1, 9'd511, '0);
    step(1'b0, 1'b1, 9'd5, '0);
    lat = 0;
    while (!bus.o_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_v0", 32'(bus.o_rvalid), 1);
    @(negedge clk);
    check("b2b_v1", 32'(bus.o_rvalid), 1);
    @(negedge clk);
    check("b2b_v2", 32'(bus.o_rvalid), 1);
    @(negedge clk);
    check("b2b_v3", 32'(bus.o_rvalid), 0);
    wait_drain();

    // Reset with two reads in flight
    step(1'b0, 1'b1, 9'd2, '0);
    step(1'b0, 1'b1, 9'd5, '0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_rvalid", 32'(bus.o_rvalid), 0);
    check("arst_rdata", bus.o_rdata, 32'hFFFF_FFFF);
    check("arst_ev", {30'd0, bus.o_1bit_event, bus.o_2bit_event}, 0);
    check_stats("arst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flushed_rvalid", 32'(bus.o_rvalid), 0);
    end
    step(1'b0, 1'b1, 9'd2, '0);
    step(1'b0, 1'b1, 9'd511, '0);
    wait_drain();

    // Saturation: five 1-bit errors
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 9'd1, '0);
    wait_drain();
    check_stats("sat", 5, 0, 1, 1);
    check("sat_c2_cnt1", 32'(bus2.o_1bit_cnt), 3);
    check("sat_c2_cnt2", 32'(bus2.o_2bit_cnt), 0);

    // Clear asserted in the same cycle as a 2-bit event
    step(1'b0, 1'b1, 9'd3, '0);
    lat = 0;
    while (!bus.o_2bit_event && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("clr_event_seen", 32'(bus.o_2bit_event), 1);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    check_stats("clr", 0, 0, 0, 0);
    check("clr_c2_cnt1", 32'(bus2.o_1bit_cnt), 0);
    check("clr_c2_sticky", 32'(bus2.o_err_sticky), 0);

    // Capture re-arms after a clear
    step(1'b0, 1'b1, 9'd1, '0);
    wait_drain();
    check_stats("rearm", 1, 0, 1, 1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
